// File: rtl/timer_pkg.sv
// Shared timer types and helpers: scheduler state encoding, default widths, round-robin search.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_COUNT  = 2'd2,
        ST_EXPIRE = 2'd3
    } timer_state_e;

    localparam int unsigned TIMER_CNT_W   = 16;
    localparam int unsigned TIMER_PRESC_W = 8;

    // Widest arbiter the search function supports; callers zero-extend narrower request vectors.
    localparam int unsigned RR_MAX_REQ   = 8;
    localparam int unsigned RR_MAX_IDX_W = 3;

    // First set bit of req searching upward from ptr, wrapping modulo n; -1 when nothing is set.
    function automatic int rr_search(input logic [RR_MAX_REQ-1:0] req,
                                     input int unsigned           ptr,
                                     input int unsigned           n);
        int          found_idx;
        int unsigned k;
        found_idx = -1;
        k         = 0;
        if (n != 0) begin
            for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
                k = (ptr + i) % n;
                if (found_idx < 0 && i < n && req[k[RR_MAX_IDX_W-1:0]]) begin
                    found_idx = int'(k);
                end
            end
        end
        return found_idx;
    endfunction

endpackage

// File: rtl/timer_share_sched_rr_pick.sv
// Combinational round-robin picker: lowest eligible index at or above rr_ptr, wrapping.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller decides when to act on valid.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    import timer_pkg::*;

    logic [RR_MAX_REQ-1:0] req_ext;
    int                    pick;

    // Widen the request vector to the search function's fixed width and decode its result.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick                 = rr_search(req_ext, 32'(rr_ptr), NUM_REQ);
        valid                = (pick >= 0);
        idx                  = valid ? IDX_W'(pick) : '0;
    end

endmodule

// File: rtl/timer_share_sched.sv
// Shares one prescaled down-counter among NUM_REQ requesters, granted round-robin.
// Latency: grant at T+1, done at T+2+L*(P+1) (T+2 when L=0); all outputs registered.
// Backpressure: requesters hold req until done or their own cancel; owner drop/cancel aborts.
module timer_share_sched
    import timer_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned CNT_W   = TIMER_CNT_W,
    parameter  int unsigned PRESC_W = TIMER_PRESC_W,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*CNT_W-1:0] load_i,
    input  logic [NUM_REQ-1:0]       cancel_i,
    input  logic [PRESC_W-1:0]       prescale_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     busy_o,
    output logic [IDX_W-1:0]         owner_o,
    output logic [CNT_W-1:0]         count_o
);

    timer_state_e         state_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [PRESC_W-1:0]   presc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   elig_d;
    logic                 pick_vld_d;
    logic [IDX_W-1:0]     pick_idx_d;
    logic [CNT_W-1:0]     load_sel_d;
    logic                 abort_d;
    logic [IDX_W-1:0]     rr_next_d;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (elig_d),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_vld_d),
        .idx    (pick_idx_d)
    );

    // Eligibility, load selection, owner abort and next round-robin pointer.
    always_comb begin
        elig_d     = req_i & ~cancel_i;
        load_sel_d = load_i[pick_idx_d*CNT_W +: CNT_W];
        abort_d    = cancel_i[owner_q] | ~req_i[owner_q];
        rr_next_d  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    end

    // Scheduler FSM; abort is checked before any count progress so cancel beats the final tick.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_d) begin
                        state_q <= ST_GRANT;
                        owner_q <= pick_idx_d;
                        gnt_q   <= NUM_REQ'(1) << pick_idx_d;
                        cnt_q   <= load_sel_d;
                        presc_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (abort_d) begin
                        state_q  <= ST_IDLE;
                        gnt_q    <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= rr_next_d;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_EXPIRE;
                        gnt_q   <= '0;
                        done_q  <= NUM_REQ'(1) << owner_q;
                    end else begin
                        state_q <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (abort_d) begin
                        state_q  <= ST_IDLE;
                        gnt_q    <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= rr_next_d;
                    end else if (presc_q == prescale_i) begin
                        presc_q <= '0;
                        cnt_q   <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= ST_EXPIRE;
                            gnt_q   <= '0;
                            done_q  <= NUM_REQ'(1) << owner_q;
                        end
                    end else begin
                        // Wraps naturally if prescale_i was lowered below the running value.
                        presc_q <= presc_q + PRESC_W'(1);
                    end
                end
                ST_EXPIRE: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    rr_ptr_q <= rr_next_d;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;
    assign owner_o = owner_q;
    assign count_o = cnt_q;

endmodule

// File: tb/tb_timer_share_sched.sv
module tb_timer_share_sched;

    localparam int NREQ = 4;
    localparam int CW   = 16;
    localparam int PW   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_i;
    logic [NREQ*CW-1:0] load_i;
    logic [NREQ-1:0]   cancel_i;
    logic [PW-1:0]     prescale_i;
    logic [NREQ-1:0]   gnt_o;
    logic [NREQ-1:0]   done_o;
    logic              busy_o;
    logic [1:0]        owner_o;
    logic [CW-1:0]     count_o;

    timer_share_sched #(
        .NUM_REQ (NREQ),
        .CNT_W   (CW),
        .PRESC_W (PW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .req_i      (req_i),
        .load_i     (load_i),
        .cancel_i   (cancel_i),
        .prescale_i (prescale_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .owner_o    (owner_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          is_done;
        int          idx;
        int          at;
        logic [CW-1:0] cnt;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        int            idx;
        logic [CW-1:0] load;
        logic [PW-1:0] presc;
        int            lat;
    } vec_t;
    vec_t vecs[8];

    int exp_cnt[9]  = '{3, 3, 3, 2, 2, 1, 1, 0, 0};
    int exp_busy[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input bit d, input int idx, input int at, input logic [CW-1:0] cnt);
        ev_t e;
        e.is_done = d;
        e.idx     = idx;
        e.at      = at;
        e.cnt     = cnt;
        exp_q.push_back(e);
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        if ($onehot(v)) begin
            for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        end
        return r;
    endfunction

    task automatic observe(input bit d, input logic [NREQ-1:0] v);
        ev_t e;
        int  i;
        i = idx_of(v);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_%s: got %b cnt %0d at cycle %0d, none required",
                     d ? "done" : "gnt", v, count_o, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_done != d || e.idx != i || e.at != cyc || count_o !== e.cnt || owner_o !== 2'(i)) begin
                n_fail++;
                $display("FAIL event: got %s idx %0d cyc %0d cnt %0d owner %0d, required %s idx %0d cyc %0d cnt %0d",
                         d ? "done" : "gnt", i, cyc, count_o, owner_o,
                         e.is_done ? "done" : "gnt", e.idx, e.at, e.cnt);
            end
        end
    endtask

    // Monitor: grant rising edges and done pulses are matched against the scoreboard.
    logic [NREQ-1:0] gnt_prev = '0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (gnt_o != '0 && gnt_prev == '0) observe(1'b0, gnt_o);
            if (done_o != '0) observe(1'b1, done_o);
        end
        gnt_prev = gnt_o;
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_o === 1'b1 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_timeout", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input int idx, input logic [CW-1:0] v);
        load_i[idx*CW +: CW] = v;
    endtask

    int n;

    initial begin
        vecs[0] = '{0, 16'd3, 8'd1,   8};
        vecs[1] = '{1, 16'd0, 8'd3,   2};
        vecs[2] = '{2, 16'd1, 8'd0,   3};
        vecs[3] = '{3, 16'd4, 8'd2,   14};
        vecs[4] = '{0, 16'd2, 8'd4,   12};
        vecs[5] = '{1, 16'd5, 8'd0,   7};
        vecs[6] = '{2, 16'd1, 8'd255, 258};
        vecs[7] = '{3, 16'd3, 8'd1,   8};

        rst_n      = 1'b0;
        req_i      = '0;
        load_i     = '0;
        cancel_i   = '0;
        prescale_i = '0;
        #1;
        check("rst_gnt",   32'(gnt_o),   32'd0);
        check("rst_done",  32'(done_o),  32'd0);
        check("rst_busy",  32'(busy_o),  32'd0);
        check("rst_owner", 32'(owner_o), 32'd0);
        check("rst_count", 32'(count_o), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All four requesting, loads 1, prescale 0: grants 0,1,2,3 then 0 again.
        for (int j = 0; j < NREQ; j++) set_load(j, 16'd1);
        prescale_i = 8'd0;
        n = cyc;
        req_i = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            push(1'b0, k, n + 1 + 4*k, 16'd1);
            push(1'b1, k, n + 3 + 4*k, 16'd0);
        end
        push(1'b0, 0, n + 17, 16'd1);
        push(1'b1, 0, n + 19, 16'd0);
        wait_cyc(n + 7);  req_i[1] = 1'b0;
        wait_cyc(n + 11); req_i[2] = 1'b0;
        wait_cyc(n + 15); req_i[3] = 1'b0;
        wait_cyc(n + 19); req_i[0] = 1'b0;
        wait_idle();

        // Single requester 0, load 3, prescale 1: cycle-by-cycle count and busy.
        set_load(0, 16'd3);
        prescale_i = 8'd1;
        n = cyc;
        req_i = 4'b0001;
        push(1'b0, 0, n + 1, 16'd3);
        push(1'b1, 0, n + 8, 16'd0);
        for (int k = 1; k <= 9; k++) begin
            wait_cyc(n + k);
            @(negedge clk);
            check($sformatf("seq_count_t%0d", k), 32'(count_o), 32'(exp_cnt[k-1]));
            check($sformatf("seq_busy_t%0d", k),  32'(busy_o),  32'(exp_busy[k-1]));
            if (k == 8) req_i[0] = 1'b0;
        end
        wait_idle();

        // Owner 2 cancelled at count 5; pending 3 served ahead of 0.
        set_load(2, 16'd7);
        prescale_i = 8'd0;
        n = cyc;
        req_i = 4'b0100;
        push(1'b0, 2, n + 1, 16'd7);
        wait_cyc(n + 2);
        set_load(3, 16'd2);
        set_load(0, 16'd1);
        req_i = 4'b1101;
        wait_cyc(n + 4);
        @(negedge clk);
        check("cancel_pre_count", 32'(count_o), 32'd5);
        cancel_i[2] = 1'b1;
        wait_cyc(n + 5);
        cancel_i = '0;
        req_i[2] = 1'b0;
        push(1'b0, 3, n + 6,  16'd2);
        push(1'b1, 3, n + 9,  16'd0);
        push(1'b0, 0, n + 11, 16'd1);
        push(1'b1, 0, n + 13, 16'd0);
        @(negedge clk);
        check("cancel_gnt",   32'(gnt_o),   32'd0);
        check("cancel_done",  32'(done_o),  32'd0);
        check("cancel_busy",  32'(busy_o),  32'd0);
        check("cancel_count", 32'(count_o), 32'd5);
        wait_cyc(n + 9);  req_i[3] = 1'b0;
        wait_cyc(n + 13); req_i[0] = 1'b0;
        wait_idle();

        // Load 0 on requester 1: straight from grant to expire.
        set_load(1, 16'd0);
        prescale_i = 8'd3;
        n = cyc;
        req_i = 4'b0010;
        push(1'b0, 1, n + 1, 16'd0);
        push(1'b1, 1, n + 2, 16'd0);
        wait_cyc(n + 2);
        req_i = '0;
        wait_cyc(n + 3);
        @(negedge clk);
        check("load0_busy_after", 32'(busy_o), 32'd0);
        wait_idle();

        // Cancel coinciding with the final 1->0 decrement: no done.
        set_load(0, 16'd1);
        prescale_i = 8'd0;
        n = cyc;
        req_i = 4'b0001;
        push(1'b0, 0, n + 1, 16'd1);
        wait_cyc(n + 2);
        cancel_i[0] = 1'b1;
        wait_cyc(n + 3);
        cancel_i = '0;
        req_i    = '0;
        @(negedge clk);
        check("lastcancel_done",  32'(done_o),  32'd0);
        check("lastcancel_busy",  32'(busy_o),  32'd0);
        check("lastcancel_gnt",   32'(gnt_o),   32'd0);
        check("lastcancel_count", 32'(count_o), 32'd1);
        repeat (4) @(posedge clk);
        #1;

        // Reset pulsed mid-count clears outputs asynchronously and the round-robin pointer.
        set_load(2, 16'd10);
        prescale_i = 8'd2;
        n = cyc;
        req_i = 4'b0100;
        push(1'b0, 2, n + 1, 16'd10);
        wait_cyc(n + 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gnt",   32'(gnt_o),   32'd0);
        check("arst_done",  32'(done_o),  32'd0);
        check("arst_busy",  32'(busy_o),  32'd0);
        check("arst_owner", 32'(owner_o), 32'd0);
        check("arst_count", 32'(count_o), 32'd0);
        req_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_busy_after", 32'(busy_o), 32'd0);
        set_load(0, 16'd1);
        set_load(1, 16'd1);
        prescale_i = 8'd0;
        n = cyc;
        req_i = 4'b0011;
        push(1'b0, 0, n + 1, 16'd1);
        push(1'b1, 0, n + 3, 16'd0);
        push(1'b0, 1, n + 5, 16'd1);
        push(1'b1, 1, n + 7, 16'd0);
        wait_cyc(n + 3); req_i[0] = 1'b0;
        wait_cyc(n + 7); req_i[1] = 1'b0;
        wait_idle();

        // Requester 0 held through its done with nobody else pending: back-to-back reuse.
        set_load(0, 16'd2);
        prescale_i = 8'd1;
        n = cyc;
        req_i = 4'b0001;
        push(1'b0, 0, n + 1,  16'd2);
        push(1'b1, 0, n + 6,  16'd0);
        push(1'b0, 0, n + 8,  16'd2);
        push(1'b1, 0, n + 13, 16'd0);
        wait_cyc(n + 13);
        req_i = '0;
        wait_idle();

        // Table of single-requester transactions with hand-derived done latency.
        for (int v = 0; v < 8; v++) begin
            wait_idle();
            for (int j = 0; j < NREQ; j++) set_load(j, 16'($urandom));
            set_load(vecs[v].idx, vecs[v].load);
            prescale_i = vecs[v].presc;
            n = cyc;
            req_i = 4'b0001 << vecs[v].idx;
            push(1'b0, vecs[v].idx, n + 1, vecs[v].load);
            push(1'b1, vecs[v].idx, n + vecs[v].lat, 16'd0);
            wait_cyc(n + vecs[v].lat);
            req_i = '0;
        end
        wait_idle();
        repeat (5) @(posedge clk);
        #1;

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_%s: idx %0d required at cycle %0d, never seen",
                     e.is_done ? "done" : "gnt", e.idx, e.at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
